uart_rx: RTL and testbench

Asynchronous serial receiver for the 50 MHz UART link at 115200 baud, 8N1 format (optional even-parity bit). It samples the `rx` line mid-bit, assembles one byte LSB-first and presents it with a one-cycle `valid` strobe. It also flags malformed frames. It sits between the board RX pin and byte-level consumer logic, as the receiving end of the line driven by the team's UART transmitter.

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial receive bundle: the RX pin plus the byte-level outputs of uart_rx.
// The receiver uses the master modport; consumers and testbenches use slave.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    modport master (
        input  rx,
        output data,
        output valid,
        output frame_err,
        output parity_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default and 8E1 when UART_RX_PARITY_EN is defined.
// Samples mid-bit, shifts LSB-first, and flags framing and parity errors.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4,
        PARITY = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    data_r, data_n;
    logic          valid_r, valid_n;
    logic          ferr_r, ferr_n;
    logic          busy_r, busy_n;
    logic          rx_meta, rx_s;

    // Two-flop synchronizer; both stages reset to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n;
    logic perr_r, perr_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            perr_r  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            data_r  <= data_n;
            valid_r <= valid_n;
            ferr_r  <= ferr_n;
            busy_r  <= busy_n;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_n;
            perr_r  <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = data_r;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt == HALF_LAST) begin
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    par_bad_n = rx_s ^ (^shreg);
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_LAST) begin
                    if (rx_s) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_n  = par_bad;
`endif
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger.
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_n != state) cnt_n = '0;
        busy_n = (state_n != IDLE);
    end

    assign bus.data      = data_r;
    assign bus.valid     = valid_r;
    assign bus.frame_err = ferr_r;
    assign bus.busy      = busy_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_r;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 434 clocks per bit: directed table,
// hand-written corner sequences and randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLKS = 434;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int EVENT_REL  = 4560;
    localparam bit PARITY_BUILD = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam int EVENT_REL  = 4126;
    localparam bit PARITY_BUILD = 1'b0;
`endif
    localparam int BUSY_REL = 3;

    typedef struct {
        logic [7:0] b;
        logic       stop_bit;
        logic       par_bit;
        int         bit_len;
        int         gap;
        logic       exp_valid;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if bus();

    uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int unsigned edge_count = 0;
    logic        rst_at_edge = 1'b0;

    always @(posedge clk) begin
        edge_count  <= edge_count + 1;
        rst_at_edge <= rst;
    end

    int unsigned frame_start = 0;
    int unsigned valid_times[$];
    int unsigned ferr_times[$];
    int unsigned perr_times[$];
    int unsigned busy_rises[$];
    logic [7:0]  prev_data = 8'h00;
    logic        prev_busy = 1'b0;
    int          data_glitches = 0;
    int          compared = 0;
    int          mismatched = 0;

    // Event recorder: pulses are logged with the edge count at which they are visible.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) valid_times.push_back(edge_count);
        if (bus.frame_err === 1'b1) ferr_times.push_back(edge_count);
        if (bus.parity_err === 1'b1) perr_times.push_back(edge_count);
        if (bus.busy === 1'b1 && prev_busy !== 1'b1) busy_rises.push_back(edge_count);
        if (bus.valid !== 1'b1 && rst_at_edge !== 1'b1 && bus.data !== prev_data) data_glitches++;
        prev_data = bus.data;
        prev_busy = bus.busy;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic clear_events();
        valid_times.delete();
        ferr_times.delete();
        perr_times.delete();
        busy_rises.delete();
    endtask

    // Drives one full frame onto rx, starting and ending on a falling clock edge.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input logic par_bit, input int bit_len);
        logic [10:0] frame;
        frame = {stop_bit, (FRAME_BITS == 11) ? par_bit : stop_bit, b, 1'b0};
        clear_events();
        frame_start = edge_count;
        for (int i = 0; i < FRAME_BITS; i++) begin
            bus.rx = frame[i];
            repeat (bit_len) @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input logic exp_valid, input logic exp_ferr,
                               input logic exp_perr, input logic [7:0] exp_data);
        int unsigned t;
        checkOutput({tag, " valid count"}, 32'(valid_times.size()), 32'(exp_valid));
        checkOutput({tag, " frame_err count"}, 32'(ferr_times.size()), 32'(exp_ferr));
        checkOutput({tag, " parity_err count"}, 32'(perr_times.size()), 32'(exp_perr));
        checkOutput({tag, " data"}, 32'(bus.data), 32'(exp_data));
        t = (busy_rises.size() > 0) ? busy_rises[0] - frame_start : 32'hFFFF_FFFF;
        checkOutput({tag, " busy rise cycle"}, t, BUSY_REL);
        if (exp_valid) begin
            t = (valid_times.size() > 0) ? valid_times[0] - frame_start : 32'hFFFF_FFFF;
            checkOutput({tag, " valid cycle"}, t, EVENT_REL);
        end
        if (exp_ferr) begin
            t = (ferr_times.size() > 0) ? ferr_times[0] - frame_start : 32'hFFFF_FFFF;
            checkOutput({tag, " frame_err cycle"}, t, EVENT_REL);
        end
        if (exp_perr) begin
            t = (perr_times.size() > 0) ? perr_times[0] - frame_start : 32'hFFFF_FFFF;
            checkOutput({tag, " parity_err cycle"}, t, EVENT_REL);
        end
    endtask

    initial begin
        vec_t        vecs[5];
        int unsigned valid_abs[5];
        logic [7:0]  last_good;
        logic [7:0]  abort_byte;
        logic [7:0]  rb;
        logic        rstop, rpar, e_valid, e_ferr, e_perr;
        logic [7:0]  e_data;
        int          rlen;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, CLKS,     30, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1'b0, CLKS,      0, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, CLKS,     30, 1'b1, 1'b0, 8'hFF};
        vecs[3] = '{8'h5A, 1'b1, 1'b0, CLKS - 9, 30, 1'b1, 1'b0, 8'h5A};
        vecs[4] = '{8'hC3, 1'b1, 1'b0, CLKS + 9, 30, 1'b1, 1'b0, 8'hC3};

        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset data", 32'(bus.data), 32'h00);
        checkOutput("reset valid", 32'(bus.valid), 32'h0);
        checkOutput("reset frame_err", 32'(bus.frame_err), 32'h0);
        checkOutput("reset parity_err", 32'(bus.parity_err), 32'h0);
        checkOutput("reset busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        last_good = 8'h00;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].b, vecs[i].stop_bit, vecs[i].par_bit, vecs[i].bit_len);
            bus.rx = 1'b1;
            check_frame($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ferr, 1'b0, vecs[i].exp_data);
            valid_abs[i] = (valid_times.size() > 0) ? valid_times[0] : 32'h0;
            last_good = vecs[i].exp_data;
            repeat (vecs[i].gap) @(negedge clk);
        end
        checkOutput("back-to-back valid spacing", valid_abs[2] - valid_abs[1], 32'(FRAME_BITS * CLKS));

        // Short low pulse: START must reject it at mid-bit.
        clear_events();
        frame_start = edge_count;
        bus.rx = 1'b0;
        repeat (100) @(negedge clk);
        bus.rx = 1'b1;
        repeat (300) @(negedge clk);
        check_frame("glitch", 1'b0, 1'b0, 1'b0, last_good);
        checkOutput("glitch busy back low", 32'(bus.busy), 32'h0);

        // Bad stop bit with the line then held low.
        applyStimulus(8'h3C, 1'b0, 1'b0, CLKS);
        check_frame("bad stop 3C", 1'b0, 1'b1, 1'b0, last_good);
        repeat (2000) @(negedge clk);
        checkOutput("held low frame_err count", 32'(ferr_times.size()), 32'h1);
        checkOutput("held low valid count", 32'(valid_times.size()), 32'h0);
        checkOutput("held low busy", 32'(bus.busy), 32'h1);
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("after break busy", 32'(bus.busy), 32'h0);
        applyStimulus(8'h12, 1'b1, 1'b0, CLKS);
        bus.rx = 1'b1;
        check_frame("after break 12", 1'b1, 1'b0, 1'b0, 8'h12);
        last_good = 8'h12;
        repeat (30) @(negedge clk);

        // Reset in the middle of data bit 4 of 0x81.
        clear_events();
        frame_start = edge_count;
        abort_byte  = 8'h81;
        bus.rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = abort_byte[i];
            repeat (CLKS) @(negedge clk);
        end
        bus.rx = abort_byte[4];
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort reset data", 32'(bus.data), 32'h00);
        checkOutput("abort reset valid", 32'(bus.valid), 32'h0);
        checkOutput("abort reset frame_err", 32'(bus.frame_err), 32'h0);
        checkOutput("abort reset busy", 32'(bus.busy), 32'h0);
        rst    = 1'b0;
        bus.rx = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("abort valid count", 32'(valid_times.size()), 32'h0);
        checkOutput("abort frame_err count", 32'(ferr_times.size()), 32'h0);
        last_good = 8'h00;
        applyStimulus(8'h7E, 1'b1, 1'b0, CLKS);
        bus.rx = 1'b1;
        check_frame("after abort 7E", 1'b1, 1'b0, 1'b0, 8'h7E);
        last_good = 8'h7E;
        repeat (30) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h07, 1'b1, 1'b1, CLKS);
        bus.rx = 1'b1;
        check_frame("parity good 07", 1'b1, 1'b0, 1'b0, 8'h07);
        repeat (30) @(negedge clk);
        applyStimulus(8'h07, 1'b1, 1'b0, CLKS);
        bus.rx = 1'b1;
        check_frame("parity bad 07", 1'b1, 1'b0, 1'b1, 8'h07);
        last_good = 8'h07;
        repeat (30) @(negedge clk);
`endif

        // Random frames: the model works purely from the byte, stop bit and parity bit sent.
        for (int k = 0; k < 3; k++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rpar  = 1'($urandom_range(0, 1));
            rlen  = int'($urandom_range(CLKS - 9, CLKS + 9));
            e_valid = rstop;
            e_ferr  = !rstop;
            e_perr  = PARITY_BUILD && rstop && ((($countones(rb) + int'(rpar)) % 2) == 1);
            e_data  = rstop ? rb : last_good;
            applyStimulus(rb, rstop, rpar, rlen);
            bus.rx = 1'b1;
            check_frame($sformatf("random%0d byte %0h stop %0d len %0d", k, rb, rstop, rlen),
                        e_valid, e_ferr, e_perr, e_data);
            last_good = e_data;
            repeat (rstop ? int'($urandom_range(0, 20)) : 30) @(negedge clk);
        end

        checkOutput("data changes without valid", 32'(data_glitches), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
